// File: rtl/stream_unlabeler.sv
// AXI-Stream label stripper: leading LABEL_BEATS beats become out_tid, payload is forwarded.
// Optional packet/short counters are enabled with `define STREAM_UNLABELER_STATS_EN.
module stream_unlabeler #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_BEATS = 1,
  parameter int ID_WIDTH    = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tlast,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tlast,
  output logic [ID_WIDTH-1:0]   out_tid,
`ifdef STREAM_UNLABELER_STATS_EN
  output logic [15:0]           pkt_count,
  output logic [15:0]           short_count,
`endif
  output logic                  short_pkt
);

  localparam int CW  = (LABEL_BEATS > 1) ? $clog2(LABEL_BEATS) : 1;
  localparam int LBW = DATA_WIDTH * LABEL_BEATS;
  localparam logic [CW-1:0] LAST_CNT = CW'(LABEL_BEATS - 1);

  typedef enum logic {S_LABEL, S_PAYLOAD} state_t;

  state_t          state;
  logic [CW-1:0]   lbl_cnt;
  logic [LBW-1:0]  lbl_q;
  logic [LBW-1:0]  lbl_next;
  logic            acc;

  assign in_tready = !out_tvalid || out_tready;
  assign acc       = in_tvalid && in_tready;

  // Label as it will look once the current beat lands; lets out_tid load in the same cycle.
  always_comb begin
    lbl_next = lbl_q;
    for (int b = 0; b < LABEL_BEATS; b++)
      if (lbl_cnt == CW'(b)) lbl_next[b*DATA_WIDTH +: DATA_WIDTH] = in_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= S_LABEL;
      lbl_cnt    <= '0;
      lbl_q      <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
      short_pkt  <= 1'b0;
    end else begin
      short_pkt <= 1'b0;
      if (out_tready) out_tvalid <= 1'b0;
      if (acc) begin
        case (state)
          S_LABEL: begin
            lbl_q <= lbl_next;
            if (in_tlast) begin
              short_pkt <= 1'b1;
              lbl_cnt   <= '0;
            end else if (lbl_cnt == LAST_CNT) begin
              out_tid <= lbl_next[ID_WIDTH-1:0];
              lbl_cnt <= '0;
              state   <= S_PAYLOAD;
            end else begin
              lbl_cnt <= lbl_cnt + CW'(1);
            end
          end
          S_PAYLOAD: begin
            out_tvalid <= 1'b1;
            out_tdata  <= in_tdata;
            out_tlast  <= in_tlast;
            if (in_tlast) state <= S_LABEL;
          end
          default: state <= S_LABEL;
        endcase
      end
    end
  end

`ifdef STREAM_UNLABELER_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_count   <= '0;
      short_count <= '0;
    end else begin
      if (acc && state == S_PAYLOAD && in_tlast) pkt_count <= pkt_count + 16'd1;
      if (short_pkt) short_count <= short_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_unlabeler.sv
// Directed bench for stream_unlabeler: 1-beat label instance (a_*) and 2-beat/12-bit-id instance (b_*).
module tb_stream_unlabeler;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic       a_in_tvalid, a_in_tready, a_in_tlast, a_out_tvalid, a_out_tready, a_out_tlast, a_short;
  logic [7:0] a_in_tdata, a_out_tdata, a_out_tid;
  logic       b_in_tvalid, b_in_tready, b_in_tlast, b_out_tvalid, b_out_tready, b_out_tlast, b_short;
  logic [7:0] b_in_tdata, b_out_tdata;
  logic [11:0] b_out_tid;
`ifdef STREAM_UNLABELER_STATS_EN
  logic [15:0] a_pkt, a_sc, b_pkt, b_sc;
`endif

  stream_unlabeler #(.DATA_WIDTH(8), .LABEL_BEATS(1), .ID_WIDTH(8)) u_a (
    .aclk(aclk), .aresetn(aresetn),
    .in_tvalid(a_in_tvalid), .in_tready(a_in_tready), .in_tdata(a_in_tdata), .in_tlast(a_in_tlast),
    .out_tvalid(a_out_tvalid), .out_tready(a_out_tready), .out_tdata(a_out_tdata),
    .out_tlast(a_out_tlast), .out_tid(a_out_tid),
`ifdef STREAM_UNLABELER_STATS_EN
    .pkt_count(a_pkt), .short_count(a_sc),
`endif
    .short_pkt(a_short));

  stream_unlabeler #(.DATA_WIDTH(8), .LABEL_BEATS(2), .ID_WIDTH(12)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .in_tvalid(b_in_tvalid), .in_tready(b_in_tready), .in_tdata(b_in_tdata), .in_tlast(b_in_tlast),
    .out_tvalid(b_out_tvalid), .out_tready(b_out_tready), .out_tdata(b_out_tdata),
    .out_tlast(b_out_tlast), .out_tid(b_out_tid),
`ifdef STREAM_UNLABELER_STATS_EN
    .pkt_count(b_pkt), .short_count(b_sc),
`endif
    .short_pkt(b_short));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [7:0] d, input logic l);
    a_in_tvalid = v; a_in_tdata = d; a_in_tlast = l;
  endtask

  task automatic b_drive(input logic v, input logic [7:0] d, input logic l);
    b_in_tvalid = v; b_in_tdata = d; b_in_tlast = l;
  endtask

  task automatic a_out(input string tag, input logic v, input logic [7:0] d, input logic l,
                       input logic [7:0] id);
    check({tag, "_vld"}, 32'(a_out_tvalid), 32'(v));
    if (v) begin
      check({tag, "_data"}, 32'(a_out_tdata), 32'(d));
      check({tag, "_last"}, 32'(a_out_tlast), 32'(l));
    end
    check({tag, "_tid"}, 32'(a_out_tid), 32'(id));
  endtask

  initial begin
    aresetn = 1'b0;
    a_drive(1'b0, 8'h00, 1'b0); a_out_tready = 1'b1;
    b_drive(1'b0, 8'h00, 1'b0); b_out_tready = 1'b1;
    step(); step();
    aresetn = 1'b1;

    // reset state
    check("rst_vld", 32'(a_out_tvalid), 32'd0);
    check("rst_data", 32'(a_out_tdata), 32'd0);
    check("rst_last", 32'(a_out_tlast), 32'd0);
    check("rst_tid", 32'(a_out_tid), 32'd0);
    check("rst_short", 32'(a_short), 32'd0);
    check("rst_rdy", 32'(a_in_tready), 32'd1);
    check("rst_b_tid", 32'(b_out_tid), 32'd0);

    // short packet (tlast on the label beat), then a good one
    a_drive(1'b1, 8'h07, 1'b1); step();
    check("short_pulse", 32'(a_short), 32'd1);
    a_out("short", 1'b0, 8'h00, 1'b0, 8'h00);
    a_drive(1'b1, 8'h09, 1'b0); step();
    check("short_pulse_end", 32'(a_short), 32'd0);
    a_out("after_short_lbl", 1'b0, 8'h00, 1'b0, 8'h09);
    a_drive(1'b1, 8'h55, 1'b1); step();
    a_out("after_short_pay", 1'b1, 8'h55, 1'b1, 8'h09);
    check("short_once", 32'(a_short), 32'd0);
    a_drive(1'b0, 8'h00, 1'b0); step();
    check("idle_vld", 32'(a_out_tvalid), 32'd0);
`ifdef STREAM_UNLABELER_STATS_EN
    check("stats_short", 32'(a_sc), 32'd1);
    check("stats_pkt", 32'(a_pkt), 32'd1);
`endif

    // basic 1-beat label packet
    a_drive(1'b1, 8'h05, 1'b0); step();
    a_out("t1_lbl", 1'b0, 8'h00, 1'b0, 8'h05);
    a_drive(1'b1, 8'hA1, 1'b0); step();
    a_out("t1_b0", 1'b1, 8'hA1, 1'b0, 8'h05);
    a_drive(1'b1, 8'hA2, 1'b1); step();
    a_out("t1_b1", 1'b1, 8'hA2, 1'b1, 8'h05);
    a_drive(1'b0, 8'h00, 1'b0); step();
    check("t1_idle", 32'(a_out_tvalid), 32'd0);

    // backpressure: beat B1 held for 3 cycles with B2 waiting
    a_drive(1'b1, 8'h0C, 1'b0); step();
    a_drive(1'b1, 8'hB1, 1'b0); step();
    a_out("bp_first", 1'b1, 8'hB1, 1'b0, 8'h0C);
    a_out_tready = 1'b0;
    a_drive(1'b1, 8'hB2, 1'b1); #1;
    check("bp_rdy_low", 32'(a_in_tready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      a_out("bp_hold", 1'b1, 8'hB1, 1'b0, 8'h0C);
      check("bp_rdy_hold", 32'(a_in_tready), 32'd0);
    end
    a_out_tready = 1'b1; #1;
    check("bp_rdy_drain", 32'(a_in_tready), 32'd1);
    step();
    a_out("bp_b2", 1'b1, 8'hB2, 1'b1, 8'h0C);
    // next label accepted while B2 drains
    a_drive(1'b1, 8'h0D, 1'b0); #1;
    check("b2b_rdy", 32'(a_in_tready), 32'd1);
    step();
    a_out("b2b_lbl", 1'b0, 8'h00, 1'b0, 8'h0D);
    a_drive(1'b1, 8'hC1, 1'b0); step();
    a_out("b2b_c1", 1'b1, 8'hC1, 1'b0, 8'h0D);
    a_drive(1'b1, 8'hC2, 1'b1); step();
    a_out("b2b_c2", 1'b1, 8'hC2, 1'b1, 8'h0D);

    // reset mid-payload
    a_drive(1'b1, 8'h0E, 1'b0); step();
    a_drive(1'b1, 8'hF1, 1'b0); step();
    a_out("mr_f1", 1'b1, 8'hF1, 1'b0, 8'h0E);
    a_drive(1'b1, 8'hF2, 1'b0); aresetn = 1'b0; step();
    check("mr_vld", 32'(a_out_tvalid), 32'd0);
    check("mr_data", 32'(a_out_tdata), 32'd0);
    check("mr_last", 32'(a_out_tlast), 32'd0);
    check("mr_tid", 32'(a_out_tid), 32'd0);
    aresetn = 1'b1;
    a_drive(1'b1, 8'h22, 1'b0); step();
    a_out("mr_lbl", 1'b0, 8'h00, 1'b0, 8'h22);
    a_drive(1'b1, 8'h33, 1'b1); step();
    a_out("mr_pay", 1'b1, 8'h33, 1'b1, 8'h22);
    a_drive(1'b0, 8'h00, 1'b0); step();
`ifdef STREAM_UNLABELER_STATS_EN
    check("stats_pkt_rst", 32'(a_pkt), 32'd1);
    check("stats_short_rst", 32'(a_sc), 32'd0);
`endif

    // two-beat label, 12-bit id
    b_drive(1'b1, 8'h34, 1'b0); step();
    check("b_lbl0_vld", 32'(b_out_tvalid), 32'd0);
    check("b_lbl0_tid", 32'(b_out_tid), 32'd0);
    b_drive(1'b1, 8'h12, 1'b0); step();
    check("b_lbl1_tid", 32'(b_out_tid), 32'h234);
    check("b_lbl1_vld", 32'(b_out_tvalid), 32'd0);
    b_drive(1'b1, 8'hEE, 1'b1); step();
    check("b_pay_vld", 32'(b_out_tvalid), 32'd1);
    check("b_pay_data", 32'(b_out_tdata), 32'hEE);
    check("b_pay_last", 32'(b_out_tlast), 32'd1);
    check("b_pay_tid", 32'(b_out_tid), 32'h234);
    // exactly LABEL_BEATS beats: dropped, tid unchanged
    b_drive(1'b1, 8'h56, 1'b0); step();
    check("b_short0", 32'(b_short), 32'd0);
    b_drive(1'b1, 8'h78, 1'b1); step();
    check("b_short_pulse", 32'(b_short), 32'd1);
    check("b_short_tid", 32'(b_out_tid), 32'h234);
    check("b_short_vld", 32'(b_out_tvalid), 32'd0);
    b_drive(1'b0, 8'h00, 1'b0); step();
    check("b_short_end", 32'(b_short), 32'd0);
`ifdef STREAM_UNLABELER_STATS_EN
    check("b_stats_pkt", 32'(b_pkt), 32'd1);
    check("b_stats_short", 32'(b_sc), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_unlabeler.md
Name: stream_unlabeler

Overview:
Parametrised AXI-Stream label stripper. The first LABEL_BEATS beats of every input packet carry a packet label. The block removes those beats, assembles them into out_tid, and forwards the remaining payload beats with out_tid held constant for the whole packet. Packets too short to carry a full label plus one payload beat are dropped and flagged. Sits between the host/DMA packet source and the per-channel ESDI command/data consumers, which route on tid.

Parameters:
DATA_WIDTH, 8, width of in_tdata/out_tdata in bits
LABEL_BEATS, 1, number of leading beats per packet forming the label (>=1)
ID_WIDTH, 8, width of out_tid; must be <= DATA_WIDTH*LABEL_BEATS; excess label bits above ID_WIDTH are discarded

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
in_tvalid  in  1  input beat valid
in_tready  out  1  input beat accepted when high with in_tvalid
in_tdata  in  DATA_WIDTH  input data (label or payload)
in_tlast  in  1  last beat of input packet
out_tvalid  out  1  output payload beat valid
out_tready  in  1  downstream ready
out_tdata  out  DATA_WIDTH  payload data
out_tlast  out  1  last payload beat of packet
out_tid  out  ID_WIDTH  label of the packet currently being output
short_pkt  out  1  one-cycle pulse: packet dropped (tlast seen during label phase)

Behaviour:
- Clock is aclk. Reset is aresetn, synchronous, active-low. It overrides everything, including mid-packet. Reset values: out_tvalid=0, out_tdata=0, out_tlast=0, out_tid=0, short_pkt=0, state=LABEL, label beat counter=0, label assembly register=0.
- in_tready = !out_tvalid || out_tready, in every state. This is combinational and allows full throughput.
- Output register: if out_tready, clear out_tvalid. A payload accept in the same cycle sets it again (set wins).
- State LABEL, with counter lbl_cnt from 0 to LABEL_BEATS-1:
  - On accept, in_tdata goes into the assembly register at bits [lbl_cnt*DATA_WIDTH +: DATA_WIDTH]. The first beat is least significant.
  - If in_tlast is set: drop the packet, pulse short_pkt the next cycle, lbl_cnt<=0, stay in LABEL, out_tid unchanged.
  - Else if lbl_cnt==LABEL_BEATS-1: load out_tid with the low ID_WIDTH bits of the assembled label (including the current beat), lbl_cnt<=0, go to PAYLOAD.
  - Else: lbl_cnt<=lbl_cnt+1.
- State PAYLOAD:
  - On accept: out_tvalid<=1, out_tdata<=in_tdata, out_tlast<=in_tlast.
  - If in_tlast is set, go to LABEL.
- Latency: a payload beat appears on out_* one cycle after acceptance. Label beats produce no output.
- out_tid changes only when the final label beat is accepted. Because in_tready requires the output register to be free or draining, out_tid is stable for every presented output beat.
- A packet with exactly LABEL_BEATS beats (tlast on the final label beat) counts as short. It is dropped with a short_pkt pulse and does not update out_tid.
- short_pkt is 0 in all cycles except the pulse.
- Back-to-back packets need no idle cycle. The label beat of packet N+1 may be accepted in the same cycle that the last beat of packet N drains.
- While out_tvalid && !out_tready, out_tdata, out_tlast and out_tid hold.

Optional Feature:
Macro STREAM_UNLABELER_STATS_EN.
- Defined: adds outputs pkt_count[15:0] and short_count[15:0], both reset to 0.
  - pkt_count increments when a payload beat with in_tlast is accepted.
  - short_count increments with every short_pkt pulse.
  - Both wrap from 0xFFFF to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- DATA_WIDTH=8, LABEL_BEATS=1, out_tready=1. Input 0x05,0xA1,0xA2(last) -> out 0xA1,0xA2 (last on 0xA2), out_tid=0x05 on both, each beat one cycle after acceptance.
- LABEL_BEATS=2, ID_WIDTH=12. Input 0x34,0x12,0xEE(last) -> single out beat 0xEE, last=1, out_tid=0x234.
- LABEL_BEATS=1. Input 0x07(last) then 0x09,0x55(last) -> short_pkt pulses once, out_tid stays 0 until it becomes 0x09, single out beat 0x55. Stats build: short_count=1, pkt_count=1.
- Backpressure: out_tready low for 3 cycles with a beat held -> in_tready=0, out_tdata/out_tid stable. Continuous in_tvalid with out_tready=1 -> one output beat per cycle across packet boundaries.
- Assert aresetn=0 mid-payload -> next cycle all outputs 0. The next packet's first beat is treated as a label.
